// File: rtl/gpio_serial_loader_if.sv
// Purpose: bundles the loader's control, register-file read and serial chain pins.
// Latency: none (wires only).
// Backpressure: none; start is a one-cycle request and busy tells the requester when it is honoured.
//
// Modports:
//   master - the loader: drives busy/done/cfg_addr/serial_*, reads start/defaults_only/cfg_data
//   slave  - housekeeping side and chain: drives start/defaults_only/cfg_data, observes the rest
interface gpio_serial_loader_if #(
    parameter int NUM_GPIO = 38,
    parameter int WIDTH    = 10
);
    localparam int AW = ($clog2(NUM_GPIO) > 1) ? $clog2(NUM_GPIO) : 1;

    logic             start;
    logic             defaults_only;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             serial_clock;
    logic             serial_load;
    logic             serial_resetn;
    logic             serial_data;

    modport master (
        input  start, defaults_only, cfg_data,
        output busy, done, cfg_addr,
        output serial_clock, serial_load, serial_resetn, serial_data
    );

    modport slave (
        output start, defaults_only, cfg_data,
        input  busy, done, cfg_addr,
        input  serial_clock, serial_load, serial_resetn, serial_data
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// Purpose: resets the GPIO config chain, then shifts one word per pad (farthest first) and strobes load.
// Latency: busy for 4*CLK_DIV + NUM_GPIO*(1+2*CLK_DIV*WIDTH) + 1 cycles (defaults_only: 2*CLK_DIV + 1).
// Backpressure: none; start is only accepted in IDLE, requests while busy are dropped.
//
// Ports: wb_clk_i (clock), wb_rstn_i (synchronous active-low reset), bus (gpio_serial_loader_if.master).
// Optional feature: define GPIO_SERIAL_LOADER_AUTOSTART_EN to run a full program after every reset.
module gpio_serial_loader #(
    parameter int NUM_GPIO = 38,
    parameter int WIDTH    = 10,
    parameter int CLK_DIV  = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    gpio_serial_loader_if.master   bus
);
    localparam int AW = ($clog2(NUM_GPIO) > 1) ? $clog2(NUM_GPIO) : 1;
    localparam int HW = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [HW-1:0] HC_LAST  = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [AW-1:0] PAD_LAST = AW'(NUM_GPIO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_FETCH, S_SHIFT, S_LOAD, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [HW-1:0]    hc;        // cycles within the current half-period
    logic             ph;        // 0 = first half (clock low), 1 = second half
    logic [BW-1:0]    bit_idx;
    logic [AW-1:0]    pad;
    logic [WIDTH-1:0] sh;
    logic             dflt;
    logic             rst_seen;  // low until the first edge out of reset
    logic             go;
    logic             go_dflt;
    logic             timed;
    logic             tick;      // last cycle of a full 2*CLK_DIV period

`ifdef GPIO_SERIAL_LOADER_AUTOSTART_EN
    // rst_seen is still 0 on the first cycle after release: treat it as a full-program start.
    assign go      = bus.start | ~rst_seen;
    assign go_dflt = bus.defaults_only & rst_seen;
`else
    assign go      = bus.start;
    assign go_dflt = bus.defaults_only;
`endif

    assign timed = (state == S_CRST) || (state == S_SHIFT) || (state == S_LOAD);
    assign tick  = timed && ph && (hc == HC_LAST);

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) state <= S_IDLE;
        else            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (go) state_nx = S_CRST;
            S_CRST:  if (tick) state_nx = dflt ? S_DONE : S_FETCH;
            S_FETCH: state_nx = S_SHIFT;
            S_SHIFT: if (tick && (bit_idx == '0)) state_nx = (pad == '0) ? S_LOAD : S_FETCH;
            S_LOAD:  if (tick) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy          = (state != S_IDLE);
        bus.done          = (state == S_DONE);
        bus.cfg_addr      = pad;
        bus.serial_clock  = 1'b0;
        bus.serial_data   = 1'b0;
        bus.serial_load   = (state == S_LOAD);
        bus.serial_resetn = rst_seen && (state != S_CRST);
        if (state == S_SHIFT) begin
            bus.serial_clock = ph;
            // bit_idx only moves at a period boundary, i.e. as the clock drops.
            bus.serial_data  = sh[bit_idx];
        end
    end

    // Timing counters and shift datapath
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            hc       <= '0;
            ph       <= 1'b0;
            bit_idx  <= '0;
            pad      <= '0;
            sh       <= '0;
            dflt     <= 1'b0;
            rst_seen <= 1'b0;
        end else begin
            rst_seen <= 1'b1;

            if (timed) begin
                if (hc == HC_LAST) begin
                    hc <= '0;
                    ph <= ~ph;
                end else begin
                    hc <= hc + 1'b1;
                end
            end else begin
                hc <= '0;
                ph <= 1'b0;
            end

            case (state)
                S_IDLE:  if (go) dflt <= go_dflt;
                S_CRST:  if (tick && !dflt) pad <= PAD_LAST;
                S_FETCH: begin
                    sh      <= bus.cfg_data;
                    bit_idx <= BIT_LAST;
                end
                S_SHIFT: if (tick) begin
                    if (bit_idx != '0)   bit_idx <= bit_idx - 1'b1;
                    else if (pad != '0)  pad     <= pad - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
Sequencer that programs the daisy-chained GPIO control blocks over their serial configuration chain.
- On request, it first pulses the chain reset so every pad falls back to its hard-wired default word.
- It then optionally shifts a per-pad configuration word for every pad and issues a load strobe.
- It sits in housekeeping, between the per-pad configuration register file (read port) and the serial chain pins.

Parameters:
NUM_GPIO, 38, number of pads on the chain (>=2)
WIDTH, 10, configuration bits per pad (matches the default-word width)
CLK_DIV, 2, wb_clk_i cycles per serial half-period (>=1)

Ports:
wb_clk_i  input  1  system clock; all state changes on its rising edge
wb_rstn_i  input  1  reset, synchronous, active-low
start  input  1  one-cycle request; honoured only in IDLE
defaults_only  input  1  sampled with start; 1 = chain reset only, no shift
busy  output  1  high from the cycle after an accepted start until DONE exits
done  output  1  one-cycle completion pulse
cfg_addr  output  max(1,$clog2(NUM_GPIO))  pad index for the register-file read
cfg_data  input  WIDTH  configuration word for cfg_addr (combinational read)
serial_clock  output  1  chain shift clock; the chain samples on its rising edge
serial_load  output  1  chain load strobe
serial_resetn  output  1  chain reset, active-low; restores pad defaults
serial_data  output  1  chain data, MSB of each word first

Behaviour:
- Clock and reset:
  - One clock, wb_clk_i. Reset wb_rstn_i is synchronous and active-low.
  - While wb_rstn_i=0, at each rising edge: state=IDLE, busy=0, done=0, cfg_addr=0, serial_clock=0, serial_load=0, serial_resetn=0, serial_data=0, all counters=0.
  - First edge with wb_rstn_i=1: serial_resetn=1.
  - Reset mid-operation aborts immediately. No partial load strobe is ever issued.
- States: IDLE, CRST, FETCH, SHIFT, LOAD, DONE.
- IDLE:
  - busy=0. start=1 -> CRST next cycle, busy=1, defaults_only latched.
  - start while not IDLE is ignored (no queueing).
- CRST:
  - serial_resetn=0 for exactly 2*CLK_DIV cycles; serial_clock=0.
  - Exit: if defaults_only -> DONE, else -> FETCH with pad index p=NUM_GPIO-1.
- FETCH (1 cycle):
  - cfg_addr=p. cfg_data captured into the WIDTH-bit shift register at the end of the cycle.
  - Bit index loaded with WIDTH-1. Next state SHIFT.
- SHIFT: each bit occupies 2*CLK_DIV cycles.
  - serial_clock=0 for the first CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - serial_data = captured[bit] and changes only on the cycle serial_clock becomes 0, giving a full half-period of setup and hold.
  - After bit 0's high phase:
    - p>0: p-1, go to FETCH.
    - p=0: go to LOAD.
  - Farthest pad (NUM_GPIO-1) is shifted first.
- LOAD: serial_clock=0, serial_load=1 for 2*CLK_DIV cycles, then DONE.
- DONE (1 cycle): done=1, serial_load=0, busy=0 next cycle, return to IDLE. done is asserted only here.
- Outputs outside SHIFT: serial_clock=0, serial_data=0.
- Busy length:
  - Full load: 2*CLK_DIV + NUM_GPIO*(1+2*CLK_DIV*WIDTH) + 2*CLK_DIV + 1 cycles, counted from the first busy cycle through the DONE cycle inclusive.
  - defaults_only: 2*CLK_DIV + 1 cycles.
- Counters:
  - Half-period counter width max(1,$clog2(CLK_DIV)).
  - Bit and pad counters wrap never; terminal compare is at 0.
- Simultaneous events: start in the same cycle as DONE is ignored. wb_rstn_i=0 dominates start.

Optional Feature:
GPIO_SERIAL_LOADER_AUTOSTART_EN
- Defined: on the first cycle after wb_rstn_i deasserts, the block behaves as if start=1 with defaults_only=0, so a full chain program runs after every reset without software action.
- Undefined: no automatic start; only the start input begins a sequence.

Test Plan:
- Reset: hold wb_rstn_i=0 for 3 cycles -> busy=0, done=0, serial_resetn=0, serial_clock=0; one cycle after release -> serial_resetn=1.
- Defaults only (CLK_DIV=2): pulse start with defaults_only=1 -> serial_resetn=0 for exactly 4 cycles, no serial_clock edges, done pulses once, busy high for 5 cycles.
- Full load (NUM_GPIO=4, WIDTH=10, CLK_DIV=2):
  - Register file holds 0x3FF, 0x000, 0x2AA, 0x155 at addresses 3..0.
  - Expect: chain model captures 40 bits in the order pad3 MSB-first, then pad2, pad1, pad0; exactly 40 serial_clock rising edges.
  - Expect: serial_load high for 4 cycles after the last edge; busy for 173 cycles; done pulses once.
- Start ignored while busy: re-pulse start mid-SHIFT -> no restart; total busy length unchanged (173); exactly one done.
- Mid-operation reset: assert wb_rstn_i=0 during pad 2 shift -> next edge all outputs at reset values, serial_load never asserted; a new start then completes a normal 173-cycle sequence.
- CLK_DIV=1 timing: every serial_data change coincides with serial_clock 1->0, and data is stable for the 1-cycle high phase; with the feature macro defined, the sequence starts automatically after reset.
